wbi_node_arbiter: RTL and testbench
===================================

# wbi_node_arbiter

Round-robin arbiter that shares one slave-side command/response channel of the Wishbone interconnect among NM master nodes. It sits between the master nodes' command/response FIFO ports (valid/ready handshakes) and a single downstream slave port. A grant is held for a whole burst: all write beats, or one read command plus every read response up to and including the last-ack beat. Responses are routed back to the granted master only.

## Interface
- NM, 4, number of master nodes (2..8)
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-enable width
- BL, 10, burst-count width

Clock and reset:
- mclk  in  1  system clock
- reset_n  in  1  reset; one clock, synchronous, active-low

Master-side command ports; vectors are packed, with master i at slice i:
- m_cmd_wval_i  in  NM  command valid per master
- m_cmd_wrdy_o  out  NM  command ready per master
- m_cmd_adr_i  in  NM*AW  address
- m_cmd_we_i  in  NM  write enable
- m_cmd_dat_i  in  NM*DW  write data
- m_cmd_sel_i  in  NM*BW  byte enables
- m_cmd_tid_i  in  NM*4  transaction id
- m_cmd_bl_i  in  NM*BL  burst count

Master-side response ports:
- m_res_rval_o  out  NM  response valid per master
- m_res_rrdy_i  in  NM  response ready per master
- m_res_dat_o, m_res_ack_o, m_res_lack_o, m_res_err_o, m_res_tid_o  out  DW/1/1/1/4  response fields, broadcast to all masters

Slave-side ports:
- s_cmd_wval_o  out  1  command valid
- s_cmd_wrdy_i  in  1  command ready
- s_cmd_adr_o, s_cmd_we_o, s_cmd_dat_o, s_cmd_sel_o, s_cmd_tid_o, s_cmd_bl_o  out  AW/1/DW/BW/4/BL  muxed command fields
- s_res_rval_i  in  1  response valid
- s_res_rrdy_o  out  1  response ready
- s_res_dat_i, s_res_ack_i, s_res_lack_i, s_res_err_i, s_res_tid_i  in  DW/1/1/1/4  response fields

## Operation
- State machine has three states: IDLE, WR_BURST, RD_BURST.
- Registers:
  - state
  - gnt: one-hot grant, NM bits
  - last: index of the most recent winner
  - bl_cnt: BL bits
  - rd_cmd_done: 1 bit
- IDLE:
  - All handshake outputs are 0.
  - If any m_cmd_wval_i is set, pick the first requester searching from last+1 upward, with wrap-around. Register that choice as gnt.
  - Load bl_cnt with the winner's bl. A bl of 0 is loaded as 1.
  - Go to WR_BURST if the winner's we=1, otherwise to RD_BURST. Clear rd_cmd_done.
- Command mux:
  - When state is not IDLE, the s_cmd_* fields equal the granted master's fields.
  - m_cmd_wrdy_o[g] = s_cmd_wrdy_i for the granted master; all other wrdy bits are 0.
- WR_BURST:
  - s_cmd_wval_o = m_cmd_wval_i[g].
  - Each accepted beat (wval & wrdy) decrements bl_cnt.
  - A beat accepted with bl_cnt==1 sends the machine to IDLE and sets last=g.
  - s_res_rrdy_o=0 and all m_res_rval_o are 0. Write responses are not routed.
- RD_BURST:
  - s_cmd_wval_o = m_cmd_wval_i[g] & !rd_cmd_done. Acceptance of the command sets rd_cmd_done.
  - m_res_rval_o[g] = s_res_rval_i, and s_res_rrdy_o = m_res_rrdy_i[g]. Response fields pass through combinationally.
  - The read is complete when a response with lack=1 is accepted (rval & rrdy). The machine then goes to IDLE and sets last=g.
- Response routing uses gnt only. s_res_tid_i is forwarded but not decoded.
- The slave's error response is passed through. It does not terminate the burst; only lack terminates a read.

## Timing
- Reset values:
  - state=IDLE, gnt=0, last=NM-1 (so master 0 wins first), bl_cnt=0, rd_cmd_done=0.
  - Every output valid/ready is 0.
- Arbitration latency: a request seen in IDLE at cycle N is granted at N+1. The earliest slave-side beat is at N+1.
- The arbiter passes one beat per cycle with no bubble inside a burst.
- After the final beat or the lack response at cycle M, the state is IDLE at M+1 and the next grant is at M+2. Every burst boundary has a one-cycle IDLE gap.
- Simultaneous requests: the round-robin order decides. A master that deasserts wval while in IDLE is not granted.
- A granted master that stalls (wval=0) keeps the grant. There is no preemption and no timeout.
- reset_n low in any state returns every register to its reset value on the next mclk edge. An in-flight burst is abandoned with no completion.

## Test plan
- Write:
  - Stimulus: master 0 writes bl=3, s_cmd_wrdy_i held at 1.
  - Required: grant 1 cycle after request; 3 consecutive s_cmd beats with we=1; return to IDLE; m_cmd_wrdy_o of the other masters stays 0 throughout.
- Round-robin:
  - Stimulus: all 4 masters request single-beat writes continuously.
  - Required: grant order 0,1,2,3,0; one IDLE gap cycle between each burst.
- Read:
  - Stimulus: master 2 reads bl=4; slave returns 4 responses, lack on the 4th; m_res_rrdy_i[2] toggles.
  - Required: exactly one s_cmd beat; responses are seen only on m_res_rval_o[2]; s_res_rrdy_o follows m_res_rrdy_i[2]; IDLE after the lack beat.
- Edge cases:
  - Stimulus: bl=0 write, then a stalled wval mid-burst.
  - Required: bl=0 behaves as 1 beat; the stalled master keeps its grant while master 1 keeps requesting.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 during beat 2 of a bl=5 write.
  - Required: all outputs 0 the next cycle; after release, master 0 is granted first.

Source files
------------

// File: rtl/wbi_node_arbiter.sv
// Round-robin arbiter sharing one slave command/response channel among NM master nodes.
// A grant is held for a whole write burst, or for one read command plus all its responses.
module wbi_node_arbiter #(
   parameter int unsigned NM = 4,
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned BW = 4,
   parameter int unsigned BL = 10
) (
   input  logic             mclk,
   input  logic             reset_n,

   input  logic [NM-1:0]    m_cmd_wval_i,
   output logic [NM-1:0]    m_cmd_wrdy_o,
   input  logic [NM*AW-1:0] m_cmd_adr_i,
   input  logic [NM-1:0]    m_cmd_we_i,
   input  logic [NM*DW-1:0] m_cmd_dat_i,
   input  logic [NM*BW-1:0] m_cmd_sel_i,
   input  logic [NM*4-1:0]  m_cmd_tid_i,
   input  logic [NM*BL-1:0] m_cmd_bl_i,

   output logic [NM-1:0]    m_res_rval_o,
   input  logic [NM-1:0]    m_res_rrdy_i,
   output logic [DW-1:0]    m_res_dat_o,
   output logic             m_res_ack_o,
   output logic             m_res_lack_o,
   output logic             m_res_err_o,
   output logic [3:0]       m_res_tid_o,

   output logic             s_cmd_wval_o,
   input  logic             s_cmd_wrdy_i,
   output logic [AW-1:0]    s_cmd_adr_o,
   output logic             s_cmd_we_o,
   output logic [DW-1:0]    s_cmd_dat_o,
   output logic [BW-1:0]    s_cmd_sel_o,
   output logic [3:0]       s_cmd_tid_o,
   output logic [BL-1:0]    s_cmd_bl_o,

   input  logic             s_res_rval_i,
   output logic             s_res_rrdy_o,
   input  logic [DW-1:0]    s_res_dat_i,
   input  logic             s_res_ack_i,
   input  logic             s_res_lack_i,
   input  logic             s_res_err_i,
   input  logic [3:0]       s_res_tid_i
);

   localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StWrBurst,
      StRdBurst
   } state_e;

   state_e        r_state;
   state_e        w_state_d;
   logic [NM-1:0] r_gnt;
   logic [NM-1:0] w_gnt_d;
   logic [LW-1:0] r_last;
   logic [LW-1:0] w_last_d;
   logic [BL-1:0] r_bl_cnt;
   logic [BL-1:0] w_bl_cnt_d;
   logic          r_rd_cmd_done;
   logic          w_rd_cmd_done_d;

   logic [LW-1:0] w_gnt_idx;
   logic          w_gnt_wval;
   logic          w_gnt_rrdy;

   logic          w_any_req;
   logic [LW-1:0] w_win_idx;
   logic          w_win_we;
   logic [BL-1:0] w_win_bl;
   int unsigned   w_rr_dist;
   int unsigned   w_rr_best;

   // Granted master's command fields; all-zero whenever no grant is held.
   always_comb begin : gnt_mux
      w_gnt_idx   = '0;
      w_gnt_wval  = 1'b0;
      w_gnt_rrdy  = 1'b0;
      s_cmd_adr_o = '0;
      s_cmd_we_o  = 1'b0;
      s_cmd_dat_o = '0;
      s_cmd_sel_o = '0;
      s_cmd_tid_o = '0;
      s_cmd_bl_o  = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (r_gnt[i]) begin
            w_gnt_idx   = LW'(i);
            w_gnt_wval  = m_cmd_wval_i[i];
            w_gnt_rrdy  = m_res_rrdy_i[i];
            s_cmd_adr_o = m_cmd_adr_i[i*AW +: AW];
            s_cmd_we_o  = m_cmd_we_i[i];
            s_cmd_dat_o = m_cmd_dat_i[i*DW +: DW];
            s_cmd_sel_o = m_cmd_sel_i[i*BW +: BW];
            s_cmd_tid_o = m_cmd_tid_i[i*4 +: 4];
            s_cmd_bl_o  = m_cmd_bl_i[i*BL +: BL];
         end
      end
   end

   // Winner is the requester at the smallest distance after the last winner.
   always_comb begin : rr_pick
      w_any_req = |m_cmd_wval_i;
      w_win_idx = '0;
      w_win_we  = 1'b0;
      w_win_bl  = '0;
      w_rr_dist = 0;
      w_rr_best = NM;
      for (int unsigned i = 0; i < NM; i++) begin
         w_rr_dist = (i + NM - 1 - 32'(r_last)) % NM;
         if (m_cmd_wval_i[i] && (w_rr_dist < w_rr_best)) begin
            w_rr_best = w_rr_dist;
            w_win_idx = LW'(i);
            w_win_we  = m_cmd_we_i[i];
            w_win_bl  = m_cmd_bl_i[i*BL +: BL];
         end
      end
   end

   always_comb begin : fsm_comb
      w_state_d       = r_state;
      w_gnt_d         = r_gnt;
      w_last_d        = r_last;
      w_bl_cnt_d      = r_bl_cnt;
      w_rd_cmd_done_d = r_rd_cmd_done;
      s_cmd_wval_o    = 1'b0;
      s_res_rrdy_o    = 1'b0;
      m_cmd_wrdy_o    = '0;
      m_res_rval_o    = '0;

      unique case (r_state)
         StIdle: begin
            if (w_any_req) begin
               w_gnt_d         = NM'(1) << w_win_idx;
               w_bl_cnt_d      = (w_win_bl == '0) ? BL'(1) : w_win_bl;
               w_rd_cmd_done_d = 1'b0;
               w_state_d       = w_win_we ? StWrBurst : StRdBurst;
            end
         end

         StWrBurst: begin
            s_cmd_wval_o = w_gnt_wval;
            m_cmd_wrdy_o = r_gnt & {NM{s_cmd_wrdy_i}};
            if (w_gnt_wval && s_cmd_wrdy_i) begin
               w_bl_cnt_d = r_bl_cnt - BL'(1);
               if (r_bl_cnt == BL'(1)) begin
                  w_state_d = StIdle;
                  w_last_d  = w_gnt_idx;
                  w_gnt_d   = '0;
               end
            end
         end

         StRdBurst: begin
            s_cmd_wval_o = w_gnt_wval & ~r_rd_cmd_done;
            m_cmd_wrdy_o = r_gnt & {NM{s_cmd_wrdy_i}};
            m_res_rval_o = r_gnt & {NM{s_res_rval_i}};
            s_res_rrdy_o = w_gnt_rrdy;
            if (s_cmd_wval_o && s_cmd_wrdy_i) begin
               w_rd_cmd_done_d = 1'b1;
            end
            // Error responses pass through; only the last-ack beat closes the read.
            if (s_res_rval_i && w_gnt_rrdy && s_res_lack_i) begin
               w_state_d = StIdle;
               w_last_d  = w_gnt_idx;
               w_gnt_d   = '0;
            end
         end

         default: begin
            w_state_d = StIdle;
            w_gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         r_state       <= StIdle;
         r_gnt         <= '0;
         r_last        <= LW'(NM - 1);
         r_bl_cnt      <= '0;
         r_rd_cmd_done <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_gnt         <= w_gnt_d;
         r_last        <= w_last_d;
         r_bl_cnt      <= w_bl_cnt_d;
         r_rd_cmd_done <= w_rd_cmd_done_d;
      end
   end

   assign m_res_dat_o  = s_res_dat_i;
   assign m_res_ack_o  = s_res_ack_i;
   assign m_res_lack_o = s_res_lack_i;
   assign m_res_err_o  = s_res_err_i;
   assign m_res_tid_o  = s_res_tid_i;

endmodule

// File: tb/tb_wbi_node_arbiter.sv
// Scoreboard bench for wbi_node_arbiter: stimulus queues expected slave beats and master
// responses with their cycle offsets; a negedge monitor pops and compares on each handshake.
module tb_wbi_node_arbiter;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int BL = 10;

   logic             mclk;
   logic             reset_n;
   logic [NM-1:0]    m_cmd_wval_i;
   logic [NM-1:0]    m_cmd_wrdy_o;
   logic [NM*AW-1:0] m_cmd_adr_i;
   logic [NM-1:0]    m_cmd_we_i;
   logic [NM*DW-1:0] m_cmd_dat_i;
   logic [NM*BW-1:0] m_cmd_sel_i;
   logic [NM*4-1:0]  m_cmd_tid_i;
   logic [NM*BL-1:0] m_cmd_bl_i;
   logic [NM-1:0]    m_res_rval_o;
   logic [NM-1:0]    m_res_rrdy_i;
   logic [DW-1:0]    m_res_dat_o;
   logic             m_res_ack_o;
   logic             m_res_lack_o;
   logic             m_res_err_o;
   logic [3:0]       m_res_tid_o;
   logic             s_cmd_wval_o;
   logic             s_cmd_wrdy_i;
   logic [AW-1:0]    s_cmd_adr_o;
   logic             s_cmd_we_o;
   logic [DW-1:0]    s_cmd_dat_o;
   logic [BW-1:0]    s_cmd_sel_o;
   logic [3:0]       s_cmd_tid_o;
   logic [BL-1:0]    s_cmd_bl_o;
   logic             s_res_rval_i;
   logic             s_res_rrdy_o;
   logic [DW-1:0]    s_res_dat_i;
   logic             s_res_ack_i;
   logic             s_res_lack_i;
   logic             s_res_err_i;
   logic [3:0]       s_res_tid_i;

   wbi_node_arbiter #(
      .NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL)
   ) u_dut (
      .mclk         (mclk),
      .reset_n      (reset_n),
      .m_cmd_wval_i (m_cmd_wval_i),
      .m_cmd_wrdy_o (m_cmd_wrdy_o),
      .m_cmd_adr_i  (m_cmd_adr_i),
      .m_cmd_we_i   (m_cmd_we_i),
      .m_cmd_dat_i  (m_cmd_dat_i),
      .m_cmd_sel_i  (m_cmd_sel_i),
      .m_cmd_tid_i  (m_cmd_tid_i),
      .m_cmd_bl_i   (m_cmd_bl_i),
      .m_res_rval_o (m_res_rval_o),
      .m_res_rrdy_i (m_res_rrdy_i),
      .m_res_dat_o  (m_res_dat_o),
      .m_res_ack_o  (m_res_ack_o),
      .m_res_lack_o (m_res_lack_o),
      .m_res_err_o  (m_res_err_o),
      .m_res_tid_o  (m_res_tid_o),
      .s_cmd_wval_o (s_cmd_wval_o),
      .s_cmd_wrdy_i (s_cmd_wrdy_i),
      .s_cmd_adr_o  (s_cmd_adr_o),
      .s_cmd_we_o   (s_cmd_we_o),
      .s_cmd_dat_o  (s_cmd_dat_o),
      .s_cmd_sel_o  (s_cmd_sel_o),
      .s_cmd_tid_o  (s_cmd_tid_o),
      .s_cmd_bl_o   (s_cmd_bl_o),
      .s_res_rval_i (s_res_rval_i),
      .s_res_rrdy_o (s_res_rrdy_o),
      .s_res_dat_i  (s_res_dat_i),
      .s_res_ack_i  (s_res_ack_i),
      .s_res_lack_i (s_res_lack_i),
      .s_res_err_i  (s_res_err_i),
      .s_res_tid_i  (s_res_tid_i)
   );

   typedef struct {
      int            off;
      logic [NM-1:0] wrdy;
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] dat;
      logic [BW-1:0] sel;
      logic [3:0]    tid;
      logic [BL-1:0] bl;
   } cmd_t;

   typedef struct {
      int            off;
      logic [NM-1:0] rval;
      logic [DW-1:0] dat;
      logic          ack;
      logic          lack;
      logic          err;
      logic [3:0]    tid;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   cmd_t mon_c;
   rsp_t mon_r;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int t0     = 0;

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   function automatic logic [BW-1:0] sel_of(input int m);
      return BW'(m) ^ {BW{1'b1}};
   endfunction

   task automatic set_m(input int m, input logic v, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input logic [BL-1:0] bl, input logic [3:0] tid);
      m_cmd_wval_i[m]           = v;
      m_cmd_we_i[m]             = we;
      m_cmd_adr_i[m*AW +: AW]   = adr;
      m_cmd_dat_i[m*DW +: DW]   = dat;
      m_cmd_sel_i[m*BW +: BW]   = sel_of(m);
      m_cmd_tid_i[m*4 +: 4]     = tid;
      m_cmd_bl_i[m*BL +: BL]    = bl;
   endtask

   task automatic push_cmd(input int off, input int m, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [BL-1:0] bl,
                           input logic [3:0] tid);
      cmd_t e;
      e.off  = off;
      e.wrdy = NM'(1) << m;
      e.adr  = adr;
      e.we   = we;
      e.dat  = dat;
      e.sel  = sel_of(m);
      e.tid  = tid;
      e.bl   = bl;
      cmd_q.push_back(e);
   endtask

   task automatic push_rsp(input int off, input int m, input logic [DW-1:0] dat,
                           input logic lack, input logic err, input logic [3:0] tid);
      rsp_t e;
      e.off  = off;
      e.rval = NM'(1) << m;
      e.dat  = dat;
      e.ack  = 1'b1;
      e.lack = lack;
      e.err  = err;
      e.tid  = tid;
      rsp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && (cmd_q.size() != 0 || rsp_q.size() != 0); i++) tick();
      check({name, "_cmd_left"}, 128'(cmd_q.size()), 128'(0));
      check({name, "_rsp_left"}, 128'(rsp_q.size()), 128'(0));
      cmd_q.delete();
      rsp_q.delete();
   endtask

   // Monitor: every slave command handshake and every master response handshake must match
   // the head of its queue, including the cycle offset from the test's request cycle.
   always @(negedge mclk) begin
      if (s_cmd_wval_o && s_cmd_wrdy_i) begin
         check("cmd_beat_expected", 128'(cmd_q.size() != 0), 128'(1));
         if (cmd_q.size() != 0) begin
            mon_c = cmd_q.pop_front();
            check("cmd_beat_time", 128'(cyc - t0), 128'(mon_c.off));
            check("cmd_beat_fields",
                  128'({m_cmd_wrdy_o, s_cmd_adr_o, s_cmd_we_o, s_cmd_dat_o, s_cmd_sel_o,
                        s_cmd_tid_o, s_cmd_bl_o}),
                  128'({mon_c.wrdy, mon_c.adr, mon_c.we, mon_c.dat, mon_c.sel, mon_c.tid,
                        mon_c.bl}));
         end
      end
      if ((m_res_rval_o & m_res_rrdy_i) != '0) begin
         check("rsp_beat_expected", 128'(rsp_q.size() != 0), 128'(1));
         if (rsp_q.size() != 0) begin
            mon_r = rsp_q.pop_front();
            check("rsp_beat_time", 128'(cyc - t0), 128'(mon_r.off));
            check("rsp_beat_fields",
                  128'({m_res_rval_o, m_res_dat_o, m_res_ack_o, m_res_lack_o, m_res_err_o,
                        m_res_tid_o}),
                  128'({mon_r.rval, mon_r.dat, mon_r.ack, mon_r.lack, mon_r.err, mon_r.tid}));
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      m_cmd_wval_i = '1;
      m_cmd_adr_i  = '0;
      m_cmd_we_i   = '0;
      m_cmd_dat_i  = '0;
      m_cmd_sel_i  = '0;
      m_cmd_tid_i  = '0;
      m_cmd_bl_i   = '0;
      m_res_rrdy_i = '1;
      s_cmd_wrdy_i = 1'b1;
      s_res_rval_i = 1'b1;
      s_res_dat_i  = '0;
      s_res_ack_i  = 1'b0;
      s_res_lack_i = 1'b0;
      s_res_err_i  = 1'b0;
      s_res_tid_i  = '0;

      // Reset state: every handshake output low even with all inputs asserted.
      tick();
      tick();
      check("rst_s_cmd_wval", 128'(s_cmd_wval_o), 128'(0));
      check("rst_m_cmd_wrdy", 128'(m_cmd_wrdy_o), 128'(0));
      check("rst_m_res_rval", 128'(m_res_rval_o), 128'(0));
      check("rst_s_res_rrdy", 128'(s_res_rrdy_o), 128'(0));
      m_cmd_wval_i = '0;
      m_res_rrdy_i = '0;
      s_res_rval_i = 1'b0;
      reset_n      = 1'b1;
      tick();
      tick();

      // Round-robin: all masters request single-beat writes; beats every other cycle.
      tick();
      t0 = cyc;
      push_cmd(1, 0, 1'b1, 32'h1000_0000, 32'h0000_00A0, 10'd1, 4'd0);
      push_cmd(3, 1, 1'b1, 32'h1000_0010, 32'h0000_00A1, 10'd1, 4'd1);
      push_cmd(5, 2, 1'b1, 32'h1000_0020, 32'h0000_00A2, 10'd1, 4'd2);
      push_cmd(7, 3, 1'b1, 32'h1000_0030, 32'h0000_00A3, 10'd1, 4'd3);
      push_cmd(9, 0, 1'b1, 32'h1000_0000, 32'h0000_00A0, 10'd1, 4'd0);
      for (int m = 0; m < NM; m++)
         set_m(m, 1'b1, 1'b1, 32'h1000_0000 + 32'(m * 16), 32'h0000_00A0 + 32'(m), 10'd1, 4'(m));
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k % 2 == 0 && k < 10) check("rr_idle_gap", 128'(s_cmd_wval_o), 128'(0));
      end
      m_cmd_wval_i = '0;
      drain("rr");

      // Write: master 0, bl=3, slave always ready.
      tick();
      t0 = cyc;
      for (int k = 1; k <= 3; k++)
         push_cmd(k, 0, 1'b1, 32'h2000_0040, 32'hDEAD_0001, 10'd3, 4'h7);
      set_m(0, 1'b1, 1'b1, 32'h2000_0040, 32'hDEAD_0001, 10'd3, 4'h7);
      check("wr_no_beat_at_req", 128'(s_cmd_wval_o), 128'(0));
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("wr_wrdy_only_m0", 128'(m_cmd_wrdy_o), 128'(4'b0001));
      end
      tick();
      m_cmd_wval_i[0] = 1'b0;
      check("wr_idle_after", 128'(m_cmd_wrdy_o), 128'(0));
      drain("wr");

      // Read: master 2, bl=4, rrdy of master 2 toggles; the other rrdy bits stay high.
      tick();
      t0 = cyc;
      push_cmd(1, 2, 1'b0, 32'h3000_0100, 32'h0000_0000, 10'd4, 4'h5);
      for (int k = 0; k < 4; k++)
         push_rsp(3 + 2 * k, 2, 32'hC0DE_0000 + 32'(k), k == 3, k == 1, 4'h5);
      set_m(2, 1'b1, 1'b0, 32'h3000_0100, 32'h0000_0000, 10'd4, 4'h5);
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         s_res_rval_i = 1'b1;
         s_res_dat_i  = 32'hC0DE_0000 + 32'(k);
         s_res_ack_i  = 1'b1;
         s_res_lack_i = (k == 3);
         s_res_err_i  = (k == 1);
         s_res_tid_i  = 4'h5;
         m_res_rrdy_i = 4'b1011;
         if (k == 3) m_cmd_wval_i[2] = 1'b0;
         #1;
         if (k == 0) check("rd_single_cmd", 128'(s_cmd_wval_o), 128'(0));
         check("rd_rrdy_follows_low", 128'(s_res_rrdy_o), 128'(0));
         check("rd_rval_routed", 128'(m_res_rval_o), 128'(4'b0100));
         tick();
         m_res_rrdy_i = 4'b1111;
         #1;
         check("rd_rrdy_follows_high", 128'(s_res_rrdy_o), 128'(1));
      end
      tick();
      #1;
      check("rd_idle_rval", 128'(m_res_rval_o), 128'(0));
      check("rd_idle_rrdy", 128'(s_res_rrdy_o), 128'(0));
      s_res_rval_i = 1'b0;
      s_res_lack_i = 1'b0;
      s_res_err_i  = 1'b0;
      m_res_rrdy_i = '0;
      drain("rd");

      // bl=0 write from master 3 is a single beat.
      tick();
      t0 = cyc;
      push_cmd(1, 3, 1'b1, 32'h4000_0000, 32'hB0B0_0003, 10'd0, 4'h3);
      set_m(3, 1'b1, 1'b1, 32'h4000_0000, 32'hB0B0_0003, 10'd0, 4'h3);
      tick();
      tick();
      m_cmd_wval_i[3] = 1'b0;
      check("bl0_single_beat", 128'(m_cmd_wrdy_o), 128'(0));
      drain("bl0");

      // Master 0 stalls mid-burst while master 1 keeps requesting.
      tick();
      t0 = cyc;
      push_cmd(1, 0, 1'b1, 32'h5000_0000, 32'h5555_0000, 10'd2, 4'h1);
      push_cmd(4, 0, 1'b1, 32'h5000_0000, 32'h5555_0000, 10'd2, 4'h1);
      push_cmd(6, 1, 1'b1, 32'h5100_0000, 32'h1111_0000, 10'd1, 4'h2);
      set_m(0, 1'b1, 1'b1, 32'h5000_0000, 32'h5555_0000, 10'd2, 4'h1);
      set_m(1, 1'b1, 1'b1, 32'h5100_0000, 32'h1111_0000, 10'd1, 4'h2);
      tick();
      for (int k = 2; k <= 3; k++) begin
         tick();
         m_cmd_wval_i[0] = 1'b0;
         #1;
         check("stall_keeps_grant", 128'(m_cmd_wrdy_o), 128'(4'b0001));
         check("stall_no_beat", 128'(s_cmd_wval_o), 128'(0));
      end
      tick();
      m_cmd_wval_i[0] = 1'b1;
      tick();
      m_cmd_wval_i[0] = 1'b0;
      check("stall_idle_gap", 128'(m_cmd_wrdy_o), 128'(0));
      tick();
      tick();
      m_cmd_wval_i[1] = 1'b0;
      drain("stall");

      // Reset during beat 2 of a bl=5 write; afterwards master 0 beats master 2.
      tick();
      t0 = cyc;
      push_cmd(1, 0, 1'b1, 32'h6000_0000, 32'h6666_0000, 10'd5, 4'h6);
      push_cmd(2, 0, 1'b1, 32'h6000_0000, 32'h6666_0000, 10'd5, 4'h6);
      set_m(0, 1'b1, 1'b1, 32'h6000_0000, 32'h6666_0000, 10'd5, 4'h6);
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n      = 1'b1;
      s_res_rval_i = 1'b1;
      m_res_rrdy_i = '1;
      push_cmd(4, 0, 1'b1, 32'h6000_0000, 32'h6666_0001, 10'd1, 4'h6);
      push_cmd(6, 2, 1'b1, 32'h6200_0000, 32'h2222_0000, 10'd1, 4'h2);
      set_m(0, 1'b1, 1'b1, 32'h6000_0000, 32'h6666_0001, 10'd1, 4'h6);
      set_m(2, 1'b1, 1'b1, 32'h6200_0000, 32'h2222_0000, 10'd1, 4'h2);
      #1;
      check("rst_mid_s_cmd_wval", 128'(s_cmd_wval_o), 128'(0));
      check("rst_mid_m_cmd_wrdy", 128'(m_cmd_wrdy_o), 128'(0));
      check("rst_mid_m_res_rval", 128'(m_res_rval_o), 128'(0));
      check("rst_mid_s_res_rrdy", 128'(s_res_rrdy_o), 128'(0));
      s_res_rval_i = 1'b0;
      m_res_rrdy_i = '0;
      tick();
      tick();
      m_cmd_wval_i[0] = 1'b0;
      tick();
      tick();
      m_cmd_wval_i[2] = 1'b0;
      drain("rst_mid");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
